// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA sprite driver: default timing,
// total-period derivation, coordinate width and per-object field access.
package vga_pkg;
    localparam int COORD_W = 10;
    localparam int SUM_W   = COORD_W + 1;
    localparam int MAX_OBJ = 16;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_SYNC_POL = 0;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Object i's coordinate field out of a flat {.., obj1, obj0} bus.
    function automatic logic [COORD_W-1:0] obj_field(input logic [MAX_OBJ*COORD_W-1:0] v,
                                                     input int i);
        return v[i*COORD_W +: COORD_W];
    endfunction

    // start <= pos < start+len, with the end computed one bit wider so it never wraps.
    function automatic logic span_hit(input logic [COORD_W-1:0] pos,
                                      input logic [COORD_W-1:0] start,
                                      input logic [COORD_W-1:0] len);
        logic [SUM_W-1:0] w_end;
        w_end = {1'b0, start} + {1'b0, len};
        return (pos >= start) && ({1'b0, pos} < w_end);
    endfunction
endpackage

// File: rtl/vga_sprite_driver_if.sv
// Game-logic side object bus plus VGA pin/status outputs of the sprite driver.
interface vga_sprite_driver_if #(
    parameter int N_OBJ   = 3,
    parameter int COLOR_W = 4
);
    logic [N_OBJ*vga_pkg::COORD_W-1:0] obj_x;
    logic [N_OBJ*vga_pkg::COORD_W-1:0] obj_y;
    logic [N_OBJ*vga_pkg::COORD_W-1:0] obj_w;
    logic [N_OBJ*vga_pkg::COORD_W-1:0] obj_h;
    logic [N_OBJ*3*COLOR_W-1:0]        obj_rgb;
    logic [N_OBJ-1:0]                  obj_en;
    logic                              hsync;
    logic                              vsync;
    logic [COLOR_W-1:0]                r;
    logic [COLOR_W-1:0]                g;
    logic [COLOR_W-1:0]                b;
    logic [vga_pkg::COORD_W-1:0]       hpos;
    logic [vga_pkg::COORD_W-1:0]       vpos;
    logic                              active;
    logic                              frame_start;

    modport master (
        output obj_x, obj_y, obj_w, obj_h, obj_rgb, obj_en,
        input  hsync, vsync, r, g, b, hpos, vpos, active, frame_start
    );
    modport slave (
        input  obj_x, obj_y, obj_w, obj_h, obj_rgb, obj_en,
        output hsync, vsync, r, g, b, hpos, vpos, active, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider and raster counters; produces undelayed active/sync,
// the end-of-visible-frame shadow load strobe and the frame_start pulse.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = DEF_SYNC_POL
) (
    input  logic               clk,
    input  logic               rst,
    output logic               o_pix_en,
    output logic [COORD_W-1:0] o_hcnt,
    output logic [COORD_W-1:0] o_vcnt,
    output logic               o_active,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_frame_start,
    output logic               o_shadow_ld
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS_M1 = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic               POL      = (SYNC_POL != 0);

    logic [DIV_W-1:0]   r_div;
    logic [COORD_W-1:0] r_hcnt;
    logic [COORD_W-1:0] r_vcnt;
    logic               r_frame_start;
    logic               w_pix_en;
    logic               w_h_end;
    logic               w_v_end;

    // With CLK_DIV=1 DIV_LAST is 0 and the divider never leaves 0, so pix_en stays high.
    assign w_pix_en = (r_div == DIV_LAST);
    assign w_h_end  = (r_hcnt == H_LAST);
    assign w_v_end  = (r_vcnt == V_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div         <= '0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_pix_en && w_h_end && w_v_end;
            r_div         <= w_pix_en ? '0 : r_div + 1'b1;
            if (w_pix_en) begin
                if (w_h_end) begin
                    r_hcnt <= '0;
                    r_vcnt <= w_v_end ? '0 : r_vcnt + 1'b1;
                end else begin
                    r_hcnt <= r_hcnt + 1'b1;
                end
            end
        end
    end

    assign o_pix_en      = w_pix_en;
    assign o_hcnt        = r_hcnt;
    assign o_vcnt        = r_vcnt;
    assign o_active      = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    assign o_hsync       = ((r_hcnt >= HS_BEG) && (r_hcnt < HS_END)) ? POL : ~POL;
    assign o_vsync       = ((r_vcnt >= VS_BEG) && (r_vcnt < VS_END)) ? POL : ~POL;
    assign o_frame_start = r_frame_start;
    assign o_shadow_ld   = w_pix_en && w_h_end && (r_vcnt == V_VIS_M1);
endmodule

// File: rtl/vga_sprite_driver.sv
// VGA driver rendering N_OBJ priority-ordered rectangles over a background,
// with object state shadow-latched once per frame to avoid tearing.
module vga_sprite_driver
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = DEF_SYNC_POL,
    parameter int N_OBJ    = 3,
    parameter int COLOR_W  = 4,
    parameter logic [3*COLOR_W-1:0] BG_RGB = '0
) (
    input logic               clk,
    input logic               rst,
    vga_sprite_driver_if.slave bus
);
    localparam int   RGB_W = 3 * COLOR_W;
    localparam int   FW    = MAX_OBJ * COORD_W;
    localparam logic POL   = (SYNC_POL != 0);

    logic                          w_pix_en;
    logic [COORD_W-1:0]            w_hcnt;
    logic [COORD_W-1:0]            w_vcnt;
    logic                          w_active;
    logic                          w_hsync_raw;
    logic                          w_vsync_raw;
    logic                          w_frame_start;
    logic                          w_shadow_ld;
    logic [N_OBJ-1:0]              w_hit;
    logic [RGB_W-1:0]              w_pix;

    logic [N_OBJ-1:0][COORD_W-1:0] r_sx;
    logic [N_OBJ-1:0][COORD_W-1:0] r_sy;
    logic [N_OBJ-1:0][COORD_W-1:0] r_sw;
    logic [N_OBJ-1:0][COORD_W-1:0] r_sh;
    logic [N_OBJ-1:0][RGB_W-1:0]   r_srgb;
    logic [N_OBJ-1:0]              r_sen;
    logic [RGB_W-1:0]              r_rgb;
    logic                          r_hsync;
    logic                          r_vsync;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),  .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(SYNC_POL)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .o_pix_en     (w_pix_en),
        .o_hcnt       (w_hcnt),
        .o_vcnt       (w_vcnt),
        .o_active     (w_active),
        .o_hsync      (w_hsync_raw),
        .o_vsync      (w_vsync_raw),
        .o_frame_start(w_frame_start),
        .o_shadow_ld  (w_shadow_ld)
    );

    // Only the enables need reset: a cleared enable masks whatever the data shadows hold.
    always_ff @(posedge clk) begin
        if (!rst)             r_sen <= '0;
        else if (w_shadow_ld) r_sen <= bus.obj_en;
    end

    always_ff @(posedge clk) begin
        if (w_shadow_ld) begin
            r_srgb <= bus.obj_rgb;
            for (int i = 0; i < N_OBJ; i++) begin
                r_sx[i] <= obj_field(FW'(bus.obj_x), i);
                r_sy[i] <= obj_field(FW'(bus.obj_y), i);
                r_sw[i] <= obj_field(FW'(bus.obj_w), i);
                r_sh[i] <= obj_field(FW'(bus.obj_h), i);
            end
        end
    end

    for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_hit
        assign w_hit[gi] = r_sen[gi] && span_hit(w_hcnt, r_sx[gi], r_sw[gi])
                                     && span_hit(w_vcnt, r_sy[gi], r_sh[gi]);
    end

    // Scan from the top index down so the lowest hitting index is the last write.
    always_comb begin
        w_pix = BG_RGB;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (w_hit[i]) w_pix = r_srgb[i];
        end
        if (!w_active) w_pix = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rgb   <= '0;
            r_hsync <= ~POL;
            r_vsync <= ~POL;
        end else if (w_pix_en) begin
            r_rgb   <= w_pix;
            r_hsync <= w_hsync_raw;
            r_vsync <= w_vsync_raw;
        end
    end

    assign bus.r           = r_rgb[RGB_W-1 -: COLOR_W];
    assign bus.g           = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign bus.b           = r_rgb[COLOR_W-1:0];
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.hpos        = w_hcnt;
    assign bus.vpos        = w_vcnt;
    assign bus.active      = w_active;
    assign bus.frame_start = w_frame_start;
endmodule

// File: tb/tb_vga_sprite_driver.sv
// Bench for vga_sprite_driver on a shrunken raster: every clock is compared
// against a pixel-index reference model driven by directed and random steps.
module tb_vga_sprite_driver;
    localparam int CD  = 2;
    localparam int HA  = 40, HFP = 4, HSY = 6, HBP = 6;
    localparam int VA  = 30, VFP = 2, VSY = 2, VBP = 3;
    localparam int NO  = 3;
    localparam int CW  = 4;
    localparam logic [11:0] BG = 12'h125;
    localparam logic POL = 1'b0;
    localparam int HT    = HA + HFP + HSY + HBP;
    localparam int VT    = VA + VFP + VSY + VBP;
    localparam int FPIX  = HT * VT;
    localparam int FRAME = FPIX * CD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_sprite_driver_if #(.N_OBJ(NO), .COLOR_W(CW)) bus ();

    vga_sprite_driver #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(0),
        .N_OBJ(NO), .COLOR_W(CW), .BG_RGB(BG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Stimulus values currently on the bus, and the model's copy latched per frame.
    int          ox[NO], oy[NO], ow[NO], oh[NO];
    logic [11:0] orgb[NO];
    bit          oen[NO];
    int          sx[NO], sy[NO], sw[NO], sh[NO];
    logic [11:0] srgb[NO];
    bit          sen[NO];

    int n_cmp  = 0;
    int n_fail = 0;
    int n      = 0;   // clocks since reset release

    task automatic drive_objs();
        for (int i = 0; i < NO; i++) begin
            bus.obj_x[i*10 +: 10]   = 10'(ox[i]);
            bus.obj_y[i*10 +: 10]   = 10'(oy[i]);
            bus.obj_w[i*10 +: 10]   = 10'(ow[i]);
            bus.obj_h[i*10 +: 10]   = 10'(oh[i]);
            bus.obj_rgb[i*12 +: 12] = orgb[i];
            bus.obj_en[i]           = oen[i];
        end
    endtask

    task automatic set_obj(input int i, input int x, input int y, input int w, input int h,
                           input logic [11:0] c, input bit en);
        ox[i] = x; oy[i] = y; ow[i] = w; oh[i] = h; orgb[i] = c; oen[i] = en;
        drive_objs();
    endtask

    task automatic rand_objs();
        for (int i = 0; i < NO; i++) begin
            ox[i]   = $urandom_range(0, HA + 5);
            oy[i]   = $urandom_range(0, VA + 3);
            ow[i]   = $urandom_range(0, 12);
            oh[i]   = $urandom_range(0, 12);
            orgb[i] = 12'($urandom);
            oen[i]  = ($urandom_range(0, 3) != 0);
        end
        drive_objs();
    endtask

    function automatic logic [11:0] ref_color(input int h, input int v);
        if (h >= HA || v >= VA) return 12'h000;
        for (int i = 0; i < NO; i++) begin
            if (sen[i] && h >= sx[i] && h < sx[i] + sw[i] && v >= sy[i] && v < sy[i] + sh[i])
                return srgb[i];
        end
        return BG;
    endfunction

    // One clock: advance the model, compare every output, then apply the frame latch.
    task automatic step();
        logic [35:0] obs, want;
        logic [11:0] col;
        logic        hs, vs, fs, act;
        int          p, hc, vc, q, hq, vq;
        @(posedge clk);
        if (!rst) begin
            n = 0;
            for (int i = 0; i < NO; i++) sen[i] = 1'b0;
        end else begin
            n++;
        end
        #1;
        p   = n / CD;
        hc  = p % HT;
        vc  = (p / HT) % VT;
        act = (hc < HA) && (vc < VA);
        if (p == 0) begin
            col = 12'h000; hs = ~POL; vs = ~POL;
        end else begin
            q   = p - 1;
            hq  = q % HT;
            vq  = (q / HT) % VT;
            col = ref_color(hq, vq);
            hs  = (hq >= HA + HFP && hq < HA + HFP + HSY) ? POL : ~POL;
            vs  = (vq >= VA + VFP && vq < VA + VFP + VSY) ? POL : ~POL;
        end
        fs   = (p > 0) && (n % CD == 0) && (p % FPIX == 0);
        want = {hs, vs, col, 10'(hc), 10'(vc), act, fs};
        obs  = {bus.hsync, bus.vsync, bus.r, bus.g, bus.b, bus.hpos, bus.vpos, bus.active,
                bus.frame_start};
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL pixel n=%0d obs=%h exp=%h (hs,vs,rgb,hpos,vpos,act,fs)", n, obs, want);
        end
        if (n > 0 && n % CD == 0 && p % FPIX == VA * HT) begin
            for (int i = 0; i < NO; i++) begin
                sx[i] = ox[i]; sy[i] = oy[i]; sw[i] = ow[i]; sh[i] = oh[i];
                srgb[i] = orgb[i]; sen[i] = oen[i];
            end
        end
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles && n_fail < 40; k++) step();
    endtask

    task automatic wait_pos(input int h, input int v);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            step();
            if (bus.hpos == 10'(h) && bus.vpos == 10'(v)) found = 1'b1;
        end
        n_cmp++;
        assert (found) else begin
            n_fail++;
            $error("FAIL wait_pos(%0d,%0d) obs=timeout exp=reached", h, v);
        end
    endtask

    initial begin
        int  k;
        bit  seen;
        for (int i = 0; i < NO; i++) set_obj(i, 0, 0, 0, 0, 12'h000, 1'b0);
        rst = 1'b0;
        repeat (4) step();
        rst = 1'b1;

        // Single red box; first frame after reset must show only background.
        set_obj(0, 10, 5, 4, 6, 12'hF00, 1'b1);
        run(2 * FRAME);

        // Overlap: red over green, green-only strip to the right, blue underneath both.
        set_obj(0, 20, 10, 4, 4, 12'hF00, 1'b1);
        set_obj(1, 20, 10, 8, 4, 12'h0F0, 1'b1);
        set_obj(2, 22, 12, 6, 6, 12'h00F, 1'b1);
        run(FRAME);

        // Clipping at right/bottom edges, zero width, then disabled and zero height.
        set_obj(0, 36, 3, 10, 5, 12'hF0F, 1'b1);
        set_obj(1, 5, 27, 6, 10, 12'h0FF, 1'b1);
        set_obj(2, 10, 10, 0, 5, 12'hFFF, 1'b1);
        run(FRAME);
        set_obj(1, 5, 27, 6, 0, 12'h0FF, 1'b1);
        set_obj(2, 10, 10, 5, 5, 12'hFFF, 1'b0);
        run(FRAME);

        // Move an object mid-frame: current frame keeps the old x, next frame the new one.
        set_obj(0, 8, 4, 5, 20, 12'hFF0, 1'b1);
        set_obj(1, 0, 0, 0, 0, 12'h000, 1'b0);
        set_obj(2, 0, 0, 0, 0, 12'h000, 1'b0);
        run(FRAME);
        wait_pos(0, 15);
        set_obj(0, 30, 4, 5, 20, 12'hFF0, 1'b1);
        run(2 * FRAME);

        // Random objects changing at random times.
        repeat (12) begin
            rand_objs();
            run($urandom_range(500, 1200));
        end

        // Mid-line reset for three clocks, then the first frame_start one frame later.
        wait_pos(20, 10);
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        k = 0;
        seen = 1'b0;
        while (k < FRAME + 20 && !seen && n_fail < 40) begin
            step();
            k++;
            if (bus.frame_start) seen = 1'b1;
        end
        n_cmp++;
        assert (seen && k == FRAME) else begin
            n_fail++;
            $error("FAIL first_frame_start obs=%0d exp=%0d", seen ? k : -1, FRAME);
        end
        run(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_sprite_driver.md
Name: vga_sprite_driver

Overview:
- Parametrised successor to the board's VGA driver: one clock domain with an internal pixel-enable divider instead of a derived 25 MHz clock.
- Generates VGA timing and renders N_OBJ rectangular objects (paddles, ball, score blocks) over a background colour.
- Per-object position, size, colour and enable are shadow-latched once per frame, so game logic can update at any time without tearing.
- Sits between the game-logic FSM and the VGA DAC pins.

Parameters:
- CLK_DIV, 2, clk cycles per pixel (pixel-enable period); ≥1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, hsync pulse width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vsync pulse width, lines
- V_BP, 33, vertical back porch, lines
- SYNC_POL, 0, asserted level of hsync/vsync
- N_OBJ, 3, number of rectangular objects
- COLOR_W, 4, bits per colour channel
- BG_RGB, 0, background colour {r,g,b}, 3*COLOR_W bits

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous active-low reset
- obj_x  in  N_OBJ*10  per-object left edge, object i at [10i+9:10i]
- obj_y  in  N_OBJ*10  per-object top edge
- obj_w  in  N_OBJ*10  per-object width; 0 means invisible
- obj_h  in  N_OBJ*10  per-object height; 0 means invisible
- obj_rgb  in  N_OBJ*3*COLOR_W  per-object colour, packed {r,g,b}
- obj_en  in  N_OBJ  per-object enable
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- r, g, b  out  COLOR_W each  pixel colour
- hpos  out  10  current pixel column (undelayed counter)
- vpos  out  10  current line (undelayed counter)
- active  out  1  hpos/vpos lies inside the visible area (undelayed)
- frame_start  out  1  one-clk pulse when counters wrap to (0,0)

Behaviour:
- Reset (rst=0 at a clk edge):
  - divider, hcnt and vcnt go to 0
  - r/g/b = 0; hsync/vsync = !SYNC_POL; frame_start = 0
  - shadow enables cleared
  - reset mid-line aborts the frame immediately; the first pixel after release is (0,0)
- Pixel enable:
  - pix_en is high for one clk every CLK_DIV clks; the first pix_en occurs CLK_DIV clks after reset release
  - CLK_DIV=1 means pix_en is always high
- Counters (advance only on pix_en):
  - hcnt counts 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters; it wraps to 0 and vcnt increments
  - vcnt counts 0..V_TOTAL-1 and wraps to 0
- Undelayed outputs:
  - active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE)
  - hpos = hcnt; vpos = vcnt
- Sync window:
  - hsync is asserted while H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC
  - vsync uses the same rule with the V parameters
- Shadow latch:
  - all obj_* inputs are copied into shadow registers on the pix_en where hcnt = H_TOTAL-1 and vcnt = V_ACTIVE-1, i.e. the end of the last visible line
  - rendering uses shadow values only
  - inputs changing during the active area have no effect until the next frame
- Hit test, per object i, on shadow values:
  - hcnt ≥ x_i and hcnt < x_i + w_i, and vcnt ≥ y_i and vcnt < y_i + h_i, and en_i
  - sums are computed in 11 bits, so there is no wrap; objects extending past the visible area are clipped
- Priority: lowest index wins on overlap. If no object hits, the pixel takes BG_RGB. Outside the active area the pixel is forced to 0.
- Latency: r/g/b, hsync and vsync are all registered on pix_en, one pixel after the corresponding hcnt/vcnt, so colour and syncs stay mutually aligned.
- frame_start:
  - one clk, asserted on the clk following the pix_en where the counters become (0,0)
  - not asserted while in reset

Decomposition:
- Package vga_pkg holds:
  - the default timing constants
  - H_TOTAL/V_TOTAL derivation functions
  - the 10-bit coordinate width constant
  - a pack/unpack helper for object fields
- Sub-module vga_timing_gen: divider, hcnt/vcnt, active, raw syncs and frame_start.
- The top level holds the shadow registers, the hit/priority logic and the output register stage.

Test Plan:
- Reset release with default parameters → pix_en period 2 clks; hsync low for hcnt 656..751 on every line; vsync low on lines 490..491; line = 1600 clks; frame = 800×525×2 = 840000 clks; frame_start period 840000.
- obj0 at (100,50), w=10, h=20, rgb=F00, enabled → r=F/g=0/b=0 exactly at pixels x 100..109, y 50..69, one pixel late; all other visible pixels = BG_RGB; blanking region = 0.
- Overlap test: obj0 (red) and obj1 (green) both at (200,200) 8×8, plus obj1 alone at (208,200) → overlap region red, obj1-only region green.
- Change obj0_x from 100 to 300 at line 240 → remainder of the frame still draws at x=100; next frame draws at x=300 with no split frame.
- Object at x=635, w=10 or y=475, h=10 → only the visible part is drawn with no wrap to column 0 or line 0; w=0 or obj_en=0 → nothing drawn.
- Assert rst for 3 clks at hcnt=320, vcnt=100 → outputs return to reset values on the next edge; after release, timing restarts from (0,0) and the first frame_start occurs 840000 clks later.
